// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit to single-port data memory controller
module lsu_mem_ctrl #(
    parameter int DATAMEM_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES     = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    lsuop,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   store_data,
    output logic                          resp_valid,
    output logic [31:0]                   resp_data,
    output logic                          resp_err,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [3:0]                    mem_be,
    output logic [DATAMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [31:0] TMO = TIMEOUT_CYCLES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                        state;
    logic [2:0]                    op_q;
    logic [DATAMEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                   sdata_q;
    logic [31:0]                   tcnt;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0; bytes never misalign.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        logic m;
        m = 1'b0;
        if (is_half(op))
            m = a[0];
        else if (!is_byte(op))
            m = (a != 2'b00);
        return m;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] be;
        if (is_byte(op))
            be = 4'b0001 << a;
        else if (is_half(op))
            be = a[1] ? 4'b1100 : 4'b0011;
        else
            be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            OP_SB:   w = {4{d[7:0]}};
            OP_SH:   w = {2{d[15:0]}};
            OP_SW:   w = d;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            OP_LW:   r = rd;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Request acceptance, memory handshake, timeout counting and the one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 3'd0;
            addr_q     <= '0;
            sdata_q    <= 32'd0;
            tcnt       <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_data  <= 32'd0;
                    resp_err   <= 1'b0;
                    if (req_valid) begin
                        op_q    <= lsuop;
                        addr_q  <= addr[DATAMEM_ADDR_WIDTH-1:0];
                        sdata_q <= store_data;
                        tcnt    <= 32'd0;
                        if (misaligned(lsuop, addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= is_store(op_q) ? 32'd0
                                                     : extract(op_q, addr_q[1:0], mem_rdata);
                    end else if ((TMO != 32'd0) && (tcnt + 32'd1 == TMO)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= 32'd0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_data  <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_data  <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Memory-side outputs decode the held request and are forced to 0 outside ACCESS.
    always_comb begin
        req_ready = (state == IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (state == ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = is_store(op_q);
            mem_be    = lane_be(op_q, addr_q[1:0]);
            mem_addr  = {addr_q[DATAMEM_ADDR_WIDTH-1:2], 2'b00};
            mem_wdata = lane_wdata(op_q, sdata_q);
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  lsuop = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [31:0] bmem [64];
    logic [31:0] ref_mem [16];

    lsu_mem_ctrl #(.DATAMEM_ADDR_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .lsuop(lsuop), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic        we;
        int          memcyc;
        logic [31:0] data;
        logic        err;
        int          lat;
        logic        ready_after;
    } obs_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          delay;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] data;
        logic        err;
        int          memcyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One transaction, starting and ending at a falling edge; the bench acts as memory.
    task automatic txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input int delay, input bit hold, input logic [2:0] nop,
                       input logic [31:0] na, input logic [31:0] nsd, output obs_t o);
        int  n;
        int  waited;
        bit  got;
        int  idx;
        o = '{be: 4'd0, maddr: 32'd0, wdata: 32'd0, we: 1'b0, memcyc: 0,
              data: 32'd0, err: 1'b0, lat: -1, ready_after: 1'b0};
        req_valid = 1'b1; lsuop = op; addr = a; store_data = sd;
        mem_ack = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        if (hold) begin
            lsuop = nop; addr = na; store_data = nsd;
        end else begin
            req_valid = 1'b0;
        end
        waited = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
            if (resp_valid) begin
                o.data = resp_data;
                o.err  = resp_err;
                o.lat  = i;
                got    = 1'b1;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end else begin
                chk("quiet_resp_data", resp_data, 32'd0);
                chk("quiet_resp_err", {31'd0, resp_err}, 32'd0);
                if (mem_req) begin
                    if (o.memcyc == 0) begin
                        o.be = mem_be; o.maddr = {16'd0, mem_addr};
                        o.wdata = mem_wdata; o.we = mem_we;
                    end
                    o.memcyc++;
                    idx = int'(mem_addr[7:2]);
                    if (delay >= 0 && waited == delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = bmem[idx];
                        if (mem_we)
                            for (int k = 0; k < 4; k++)
                                if (mem_be[k]) bmem[idx][8*k +: 8] = mem_wdata[8*k +: 8];
                    end else begin
                        mem_ack   = 1'b0;
                        mem_rdata = $urandom;
                    end
                    waited++;
                end else begin
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
                @(negedge clk);
            end
        end
        if (!got) chk("resp_missing", 32'd0, 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        o.ready_after = req_ready;
    endtask

    vec_t vt [13];
    obs_t o;

    initial begin
        // op, a, sd, rd, delay, be, maddr, wdata, we, data, err, memcyc
        vt[0]  = '{3'd0, 32'h0000_0103, 32'h0,         32'h80FF_7F01, 0,  4'b1000, 32'h0100, 32'h0,         1'b0, 32'hFFFF_FF80, 1'b0, 1};
        vt[1]  = '{3'd6, 32'h0000_0206, 32'h1234_ABCD, 32'h0,         0,  4'b1100, 32'h0204, 32'hABCD_ABCD, 1'b1, 32'h0,         1'b0, 1};
        vt[2]  = '{3'd2, 32'h0000_0002, 32'h0,         32'h0,         0,  4'b0000, 32'h0,    32'h0,         1'b0, 32'h0,         1'b1, 0};
        vt[3]  = '{3'd4, 32'h0000_0010, 32'h0,         32'h1111_2222, -1, 4'b0011, 32'h0010, 32'h0,         1'b0, 32'h0,         1'b1, 15};
        vt[4]  = '{3'd3, 32'h0000_0001, 32'h0,         32'h0000_8000, 1,  4'b0010, 32'h0,    32'h0,         1'b0, 32'h0000_0080, 1'b0, 2};
        vt[5]  = '{3'd1, 32'h0000_0002, 32'h0,         32'h8001_0000, 2,  4'b1100, 32'h0,    32'h0,         1'b0, 32'hFFFF_8001, 1'b0, 3};
        vt[6]  = '{3'd2, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 5,  4'b1111, 32'h0004, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 6};
        vt[7]  = '{3'd5, 32'h0000_0003, 32'h0000_00A5, 32'h0,         0,  4'b1000, 32'h0,    32'hA5A5_A5A5, 1'b1, 32'h0,         1'b0, 1};
        vt[8]  = '{3'd7, 32'h0000_0008, 32'h1122_3344, 32'h0,         1,  4'b1111, 32'h0008, 32'h1122_3344, 1'b1, 32'h0,         1'b0, 2};
        vt[9]  = '{3'd6, 32'h0000_0001, 32'h5555_6666, 32'h0,         0,  4'b0000, 32'h0,    32'h0,         1'b0, 32'h0,         1'b1, 0};
        vt[10] = '{3'd0, 32'hFFFF_0105, 32'h0,         32'h0000_7F00, 0,  4'b0010, 32'h0104, 32'h0,         1'b0, 32'h0000_007F, 1'b0, 1};
        vt[11] = '{3'd2, 32'h0000_000C, 32'h0,         32'hCAFE_F00D, 14, 4'b1111, 32'h000C, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, 15};
        vt[12] = '{3'd3, 32'h0000_0002, 32'h0,         32'h0033_0000, 15, 4'b0100, 32'h0,    32'h0,         1'b0, 32'h0,         1'b1, 15};

        for (int i = 0; i < 64; i++) bmem[i] = 32'd0;

        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            bmem[(vt[i].a >> 2) & 63] = vt[i].rd;
            txn(vt[i].op, vt[i].a, vt[i].sd, vt[i].delay, 1'b0, 3'd0, 32'd0, 32'd0, o);
            chk($sformatf("v%0d_data", i), o.data, vt[i].data);
            chk($sformatf("v%0d_err", i), {31'd0, o.err}, {31'd0, vt[i].err});
            chk($sformatf("v%0d_memcyc", i), o.memcyc, vt[i].memcyc);
            chk($sformatf("v%0d_lat", i), o.lat, vt[i].memcyc);
            chk($sformatf("v%0d_be", i), {28'd0, o.be}, {28'd0, vt[i].be});
            chk($sformatf("v%0d_maddr", i), o.maddr, vt[i].maddr);
            chk($sformatf("v%0d_wdata", i), o.wdata, vt[i].wdata);
            chk($sformatf("v%0d_we", i), {31'd0, o.we}, {31'd0, vt[i].we});
            chk($sformatf("v%0d_ready_after", i), {31'd0, o.ready_after}, 32'd1);
        end

        // Back-to-back SW then LW with req_valid held high through the store
        bmem[8] = 32'h0BAD_0BAD;
        txn(3'd7, 32'h20, 32'h5A5A_1234, 3, 1'b1, 3'd2, 32'h20, 32'hFFFF_FFFF, o);
        chk("b2b_sw_we", {31'd0, o.we}, 32'd1);
        chk("b2b_sw_wdata", o.wdata, 32'h5A5A_1234);
        chk("b2b_sw_memcyc", o.memcyc, 4);
        chk("b2b_sw_err", {31'd0, o.err}, 32'd0);
        txn(3'd2, 32'h20, 32'hFFFF_FFFF, 3, 1'b0, 3'd0, 32'd0, 32'd0, o);
        chk("b2b_lw_data", o.data, 32'h5A5A_1234);
        chk("b2b_lw_memcyc", o.memcyc, 4);

        // Asynchronous reset in the middle of ACCESS
        req_valid = 1'b1; lsuop = 3'd2; addr = 32'h20; mem_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_mem_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_mem_req_async", {31'd0, mem_req}, 32'd0);
        chk("mid_ready_async", {31'd0, req_ready}, 32'd1);
        chk("mid_be_async", {28'd0, mem_be}, 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("mid_no_mem_req", {31'd0, mem_req}, 32'd0);
        end
        txn(3'd2, 32'h20, 32'd0, 0, 1'b0, 3'd0, 32'd0, 32'd0, o);
        chk("mid_after_data", o.data, 32'h5A5A_1234);
        chk("mid_after_err", {31'd0, o.err}, 32'd0);

        // Randomized transactions against a byte-level reference memory
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bmem[i]    = ref_mem[i];
        end
        for (int t = 0; t < 150; t++) begin
            logic [2:0]  op;
            logic [31:0] a, sd, exp_data, exp_wdata;
            logic [63:0] mask;
            logic [3:0]  exp_be;
            int          size, off, dly, exp_cyc;
            bit          mis, st, sgn;
            op  = 3'($urandom_range(0, 7));
            a   = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 63);
            sd  = $urandom;
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            size = (op == 0 || op == 3 || op == 5) ? 1 : (op == 1 || op == 4 || op == 6) ? 2 : 4;
            st   = (op >= 5);
            sgn  = (op == 0 || op == 1);
            off  = int'(a % 4);
            mis  = (off % size) != 0;
            exp_be    = 4'(((1 << size) - 1) << off);
            exp_wdata = !st ? 32'd0 : (size == 1) ? {24'd0, sd[7:0]} * 32'h0101_0101
                      : (size == 2) ? {16'd0, sd[15:0]} * 32'h0001_0001 : sd;
            mask = (64'd1 << (8 * size)) - 64'd1;
            exp_data = 32'((64'(ref_mem[a[5:2]]) >> (8 * off)) & mask);
            if (sgn && exp_data[8*size-1]) exp_data = exp_data | ~mask[31:0];
            exp_cyc = mis ? 0 : (dly < 0) ? 15 : dly + 1;
            if (mis || dly < 0 || st) exp_data = 32'd0;
            txn(op, a, sd, dly, 1'b0, 3'd0, 32'd0, 32'd0, o);
            if (st && !mis && dly >= 0)
                for (int k = 0; k < size; k++) ref_mem[a[5:2]][8*(off+k) +: 8] = sd[8*k +: 8];
            chk($sformatf("r%0d_err", t), {31'd0, o.err}, {31'd0, (mis || dly < 0)});
            chk($sformatf("r%0d_data", t), o.data, exp_data);
            chk($sformatf("r%0d_memcyc", t), o.memcyc, exp_cyc);
            if (!mis) begin
                chk($sformatf("r%0d_be", t), {28'd0, o.be}, {28'd0, exp_be});
                chk($sformatf("r%0d_maddr", t), o.maddr, a & 32'h0000_FFFC);
                chk($sformatf("r%0d_wdata", t), o.wdata, exp_wdata);
                chk($sformatf("r%0d_we", t), {31'd0, o.we}, {31'd0, st});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter DATAMEM_ADDR_WIDTH, default 16: width of the byte address driven to data memory.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: maximum cycles to wait for mem_ack; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 lsuop  input  3  operation: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
REQ-008 addr  input  32  byte effective address.
REQ-009 store_data  input  32  rs2 value; low bits used for SB/SH.
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 resp_data  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  qualified by resp_valid: misaligned access or memory timeout.
REQ-013 mem_req  output  1  memory access request, held until ack or timeout.
REQ-014 mem_we  output  1  1 = write.
REQ-015 mem_be  output  4  byte-lane enables; bit i selects bits [8i+7:8i].
REQ-016 mem_addr  output  DATAMEM_ADDR_WIDTH  word-aligned address: addr[DATAMEM_ADDR_WIDTH-1:2], low two bits 0.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ack  input  1  memory completes access; mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  input  32  full word read from memory.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-021 Request is accepted on a rising edge with req_valid && req_ready; lsuop, addr and store_data are registered at that edge and held stable until return to IDLE.
REQ-022 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; IDLE->RESP directly, resp_err=1, resp_data=0, mem_req never asserted.
REQ-023 Aligned accept: IDLE->ACCESS; mem_req=1 throughout ACCESS, with mem_we=1 for SB/SH/SW, else 0.
REQ-024 Store lanes: SB mem_wdata={4{byte}}, mem_be=4'b0001<<addr[1:0]; SH mem_wdata={2{half}}, mem_be=addr[1]?4'b1100:4'b0011; SW mem_wdata=store_data, mem_be=4'b1111.
REQ-025 Loads drive mem_be with the lanes actually read (same rule as stores) and mem_wdata=0.
REQ-026 mem_ack sampled high in ACCESS -> RESP next cycle; for loads, mem_rdata is captured at that edge.
REQ-027 Load extraction: byte = mem_rdata lane addr[1:0], half = lane pair addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-028 Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack; when it reaches TIMEOUT_CYCLES, ACCESS->RESP with resp_err=1 and resp_data=0; mem_req drops in the following cycle.
REQ-029 If mem_ack arrives in the same cycle the count reaches TIMEOUT_CYCLES, the ack wins and the response is successful.
REQ-030 RESP lasts exactly one cycle (resp_valid=1), then RESP->IDLE; resp_data and resp_err are 0 whenever resp_valid=0.
REQ-031 mem_ack outside ACCESS is ignored.
REQ-032 Minimum latency: accept at edge N, mem_ack in cycle N+1, resp_valid in cycle N+2, req_ready again in cycle N+3.
REQ-033 Address bits at and above DATAMEM_ADDR_WIDTH are ignored; no range error.
REQ-034 Opcodes are decoded only at accept; no other encodings exist (3-bit field fully used).

Reset
REQ-035 rst asserted: state=IDLE, timeout counter=0, registered request fields=0, immediately and independent of clk.
REQ-036 During reset all outputs are 0 except req_ready, which is 1 (IDLE).
REQ-037 Reset mid-ACCESS drops mem_req asynchronously, discards the transaction, and produces no response.

Verification
REQ-038 LB, addr=0x0000_0103, mem_rdata=0x80FF_7F01 with ack on first cycle -> resp_data=0xFFFF_FF80, resp_err=0, mem_addr=0x0100, mem_be=4'b1000.
REQ-039 SH, addr=0x0000_0206, store_data=0x1234_ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_addr=0x0204; resp_data=0.
REQ-040 LW, addr=0x0000_0002 -> resp_valid one cycle after accept, resp_err=1, mem_req stays 0.
REQ-041 LHU, addr=0x10, mem_ack never asserted, TIMEOUT_CYCLES=15 -> mem_req high 15 cycles, then resp_err=1, resp_data=0, req_ready high afterwards.
REQ-042 Back-to-back: SW then LW to 0x20, ack after 3 wait cycles each -> LW returns the stored word; req_valid held high is accepted only when req_ready=1.
REQ-043 rst pulse mid-ACCESS between clock edges -> mem_req falls without a clock edge, no resp_valid, next request completes normally.
